// File: rtl/wide_mem_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : wide_mem_line_fetcher
// Description : Read initiator for the 32-bit pixel memory. Fetches a run of
//               words under FIFO credit control, buffers the responses and
//               streams them out as bytes, LSB first, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_mem_line_fetcher #(
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [31:0]       o_mem_req_wdata,
  input  logic              i_mem_resp_valid,
  input  logic [31:0]       i_mem_resp_rdata,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [7:0]        o_pix_data,
  output logic              o_pix_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_len_zero;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_words_left;
  logic [c_CNT_W-1:0]  r_outstanding;

  logic [31:0]         r_fifo_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_fifo_count;

  logic                r_unp_valid;
  logic [31:0]         r_word;
  logic [1:0]          r_idx;
  logic                r_unp_last;
  logic [LEN_W-1:0]    r_load_left;

  logic                w_accept;
  logic [c_CNT_W:0]    w_credit_used;
  logic                w_req_valid;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_pix_hs;
  logic                w_unp_free;
  logic                w_last_hs;

  // Credits cover words already in the FIFO plus words still in flight, so a
  // response always has a slot even though the memory cannot be back-pressured.
  assign w_credit_used = {1'b0, r_fifo_count} + {1'b0, r_outstanding};
  assign w_accept      = (r_state == S_IDLE) && r_cmd_ready && i_cmd_valid;
  assign w_req_valid   = (r_state == S_ISSUE) && (r_words_left != '0) && (w_credit_used < c_DEPTH);
  assign w_issue       = w_req_valid && i_mem_req_ready;
  // A response nobody asked for is dropped rather than corrupting the FIFO.
  assign w_push        = i_mem_resp_valid && (r_outstanding != '0);
  assign w_pix_hs      = r_unp_valid && i_pix_ready;
  // Reload in the same cycle byte 3 leaves, so words stream without a bubble.
  assign w_unp_free    = !r_unp_valid || (w_pix_hs && (r_idx == 2'd3));
  assign w_pop         = w_unp_free && (r_fifo_count != '0);
  assign w_last_hs     = w_pix_hs && o_pix_last;

  assign o_cmd_ready     = r_cmd_ready;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_mem_req_valid = w_req_valid;
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_we    = 1'b0;
  assign o_mem_req_wdata = 32'd0;
  assign o_pix_valid     = r_unp_valid;
  assign o_pix_data      = r_word[8*r_idx +: 8];
  assign o_pix_last      = r_unp_valid && (r_idx == 2'd3) && r_unp_last;

  // Command sequencing: accept, issue requests, then wait for the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_len_zero   <= 1'b0;
      r_addr       <= '0;
      r_words_left <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cmd_ready stays low through the done cycle and returns after it.
          if (!r_cmd_ready) begin
            r_cmd_ready <= 1'b1;
          end else if (w_accept) begin
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_addr       <= i_cmd_addr;
            r_words_left <= i_cmd_len;
            r_len_zero   <= (i_cmd_len == '0);
            r_state      <= (i_cmd_len == '0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr       <= r_addr + ADDR_W'(1);
            r_words_left <= r_words_left - LEN_W'(1);
            if (r_words_left == LEN_W'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The final pixel can only leave once every word was delivered,
          // so its handshake alone marks completion.
          if (r_len_zero || w_last_hs) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_len_zero <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Requests accepted but not yet answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Response FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= i_mem_resp_rdata;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + c_CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - c_CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Unpacker: holds one word and steps through its bytes on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unp_valid <= 1'b0;
      r_word      <= '0;
      r_idx       <= 2'd0;
      r_unp_last  <= 1'b0;
      r_load_left <= '0;
    end else begin
      if (w_accept) begin
        r_load_left <= i_cmd_len;
      end else if (w_pop) begin
        r_load_left <= r_load_left - LEN_W'(1);
      end
      if (w_pop) begin
        r_unp_valid <= 1'b1;
        r_word      <= r_fifo_mem[r_rd_ptr];
        r_idx       <= 2'd0;
        r_unp_last  <= (r_load_left == LEN_W'(1));
      end else if (w_pix_hs) begin
        if (r_idx == 2'd3) begin
          r_unp_valid <= 1'b0;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  // A read response must always be matched by an earlier request.
  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    i_mem_resp_valid |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_wide_mem_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_mem_line_fetcher
// Description : Self-checking bench for wide_mem_line_fetcher with a 1-cycle
//               memory model and a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_mem_line_fetcher;

  localparam int AW    = 18;
  localparam int DEPTH = 4;
  localparam int LW    = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          pix_last;
  logic          busy;
  logic          done;

  wide_mem_line_fetcher #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_addr       (cmd_addr),
    .i_cmd_len        (cmd_len),
    .o_mem_req_valid  (req_valid),
    .i_mem_req_ready  (req_ready),
    .o_mem_req_we     (req_we),
    .o_mem_req_addr   (req_addr),
    .o_mem_req_wdata  (req_wdata),
    .i_mem_resp_valid (resp_valid),
    .i_mem_resp_rdata (resp_rdata),
    .o_pix_valid      (pix_valid),
    .i_pix_ready      (pix_ready),
    .o_pix_data       (pix_data),
    .o_pix_last       (pix_last),
    .o_busy           (busy),
    .o_done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];

  // Memory: answers one cycle after each accepted request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= req_valid && req_ready;
      if (req_valid && req_ready) resp_rdata <= mem[req_addr];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input drive modes: 0 = always 1, 1 = always 0, 2 = random 50%.
  int pr_mode = 0;
  int rr_mode = 0;
  initial begin
    pix_ready = 1'b1;
    req_ready = 1'b1;
    forever begin
      @(negedge clk);
      pix_ready = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      req_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model state.
  logic [7:0]    exp_b[$];
  bit            exp_l[$];
  logic [AW-1:0] exp_a[$];
  bit            m_busy = 0;
  bit            done_pend = 0;
  bit            zl_pend = 0;
  int            issued = 0;
  int            pix_out = 0;
  bit            req_stall = 0;
  logic [AW-1:0] stall_addr;
  bit            pix_stall = 0;
  logic [7:0]    stall_data;
  bit            stall_last;

  // Observations collected for per-test literal checks.
  int            cyc = 0;
  int            n_done = 0;
  int            done_cyc = 0;
  int            n_busy_cyc = 0;
  int            n_reqv_cyc = 0;
  logic [7:0]    rec_b[$];
  bit            rec_l[$];
  int            rec_c[$];
  logic [AW-1:0] rec_a[$];

  // Compare process: sampled mid-cycle, after inputs settle, before the edge.
  initial begin
    bit exp_done_now;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        exp_b.delete(); exp_l.delete(); exp_a.delete();
        m_busy = 0; done_pend = 0; zl_pend = 0;
        req_stall = 0; pix_stall = 0;
        continue;
      end
      exp_done_now = done_pend;
      done_pend = 0;
      chk("done", done, exp_done_now);
      chk("busy", busy, m_busy);
      chk("cmd_ready", cmd_ready, !m_busy && !exp_done_now);
      chk("req_we", req_we, 0);
      chk("req_wdata", req_wdata, 0);
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) n_busy_cyc++;

      if (req_valid) begin
        n_reqv_cyc++;
        if (req_stall) chk("req_addr_stable", req_addr, stall_addr);
        if (exp_a.size() == 0) chk("req_unexpected", req_valid, 0);
        else chk("req_addr", req_addr, exp_a[0]);
        if (req_ready) begin
          if (exp_a.size() != 0) void'(exp_a.pop_front());
          issued++;
          rec_a.push_back(req_addr);
          chk("credit", (issued - pix_out / 4) <= DEPTH + 1, 1);
          req_stall = 0;
        end else begin
          req_stall = 1;
          stall_addr = req_addr;
        end
      end else begin
        if (req_stall) chk("req_retracted", req_valid, 1);
        req_stall = 0;
      end

      if (pix_valid) begin
        if (pix_stall) begin
          chk("pix_data_stable", pix_data, stall_data);
          chk("pix_last_stable", pix_last, stall_last);
        end
        if (exp_b.size() == 0) begin
          chk("pix_unexpected", pix_valid, 0);
        end else begin
          chk("pix_data", pix_data, exp_b[0]);
          chk("pix_last", pix_last, exp_l[0]);
          if (pix_ready) begin
            rec_b.push_back(pix_data);
            rec_l.push_back(pix_last);
            rec_c.push_back(cyc);
            pix_out++;
            if (exp_l[0]) begin done_pend = 1; m_busy = 0; end
            void'(exp_b.pop_front());
            void'(exp_l.pop_front());
            pix_stall = 0;
          end else begin
            pix_stall = 1;
            stall_data = pix_data;
            stall_last = pix_last;
          end
        end
      end else begin
        if (pix_stall) chk("pix_retracted", pix_valid, 1);
        pix_stall = 0;
      end

      if (zl_pend) begin zl_pend = 0; done_pend = 1; m_busy = 0; end

      if (cmd_valid && cmd_ready) begin
        m_busy = 1;
        issued = 0;
        pix_out = 0;
        for (int w = 0; w < int'(cmd_len); w++) begin
          logic [AW-1:0] a;
          logic [31:0]   d;
          a = cmd_addr + AW'(w);
          d = mem[a];
          exp_a.push_back(a);
          for (int b = 0; b < 4; b++) begin
            exp_b.push_back(d[8*b +: 8]);
            exp_l.push_back((w == int'(cmd_len) - 1) && (b == 3));
          end
        end
        if (cmd_len == '0) zl_pend = 1;
      end
    end
  end

  task automatic clear_rec();
    rec_b.delete(); rec_l.delete(); rec_c.delete(); rec_a.delete();
    n_busy_cyc = 0;
    n_reqv_cyc = 0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    #3;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (!cmd_ready) chk("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k = 0;
    while (n_done == base && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    // Allow a stray second pulse to show up before counting.
    repeat (3) @(negedge clk);
    #3;
    chk("done_count", n_done - base, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_last"}, pix_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int base;
    int k;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[18'h10] = 32'h44332211;
    mem[18'h11] = 32'h88776655;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: two known words, free-flowing output.
    clear_rec();
    base = n_done;
    send_cmd(18'h10, 16'd2);
    wait_done(base, 200);
    chk("t1_count", rec_b.size(), 8);
    if (rec_b.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] e;
        e = 8'(8'h11 * (i + 1));
        chk("t1_byte", rec_b[i], e);
        chk("t1_last", rec_l[i], i == 7);
        chk("t1_consecutive", rec_c[i] - rec_c[0], i);
      end
      chk("t1_done_after_last", done_cyc - rec_c[7], 1);
    end

    // Test 2: empty command.
    clear_rec();
    base = n_done;
    send_cmd(18'h20, 16'd0);
    wait_done(base, 50);
    chk("t2_no_req", n_reqv_cyc, 0);
    chk("t2_busy_cycles", n_busy_cyc, 1);
    chk("t2_no_pix", rec_b.size(), 0);

    // Test 3: address wrap.
    clear_rec();
    base = n_done;
    send_cmd(18'h3FFFF, 16'd2);
    wait_done(base, 200);
    chk("t3_nreq", rec_a.size(), 2);
    if (rec_a.size() == 2) begin
      chk("t3_addr0", rec_a[0], 18'h3FFFF);
      chk("t3_addr1", rec_a[1], 18'h00000);
    end
    chk("t3_count", rec_b.size(), 8);
    if (rec_b.size() == 8) begin
      chk("t3_b0", rec_b[0], mem[18'h3FFFF][7:0]);
      chk("t3_b4", rec_b[4], mem[18'h00000][7:0]);
    end

    // Test 4: output blocked; issue stops once the FIFO/in-flight credits and
    // the unpacker's own word are used up.
    clear_rec();
    base = n_done;
    pr_mode = 1;
    send_cmd(18'h100, 16'd16);
    repeat (40) @(negedge clk);
    #3;
    chk("t4_stalled_issue", rec_a.size(), DEPTH + 1);
    pr_mode = 0;
    wait_done(base, 500);
    chk("t4_count", rec_b.size(), 64);
    chk("t4_model_empty", exp_b.size(), 0);

    // Test 5: random back-pressure on both sides.
    clear_rec();
    base = n_done;
    pr_mode = 2;
    rr_mode = 2;
    send_cmd(18'($urandom), 16'd100);
    wait_done(base, 5000);
    chk("t5_count", rec_b.size(), 400);
    chk("t5_model_empty", exp_b.size(), 0);
    pr_mode = 0;
    rr_mode = 0;

    // Test 6: reset in the middle of a command.
    clear_rec();
    base = n_done;
    send_cmd(18'h200, 16'd8);
    k = 0;
    while (rec_b.size() < 5 && k < 200) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("t6_reached_5", rec_b.size() >= 5, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    chk("t6_no_abort_done", n_done - base, 0);
    clear_rec();
    base = n_done;
    send_cmd(18'h300, 16'd3);
    wait_done(base, 200);
    chk("t6_new_count", rec_b.size(), 12);
    chk("t6_model_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
